// File: rtl/single_cycle_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one single-port memory.
// Data wins by default; a fetch denied STARVE_MAX consecutive cycles is forced through.
module single_cycle_mem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            m_req,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_be,
   input  logic [DW-1:0]   m_rdata
);

   localparam int unsigned CW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_t;

   owner_t        owner;
   logic          owner_store;
   logic [CW-1:0] starve_cnt;
   logic          i_win;
   logic          d_win;

   // Winner selection; gated by rst so nothing is granted while reset is held
   always_comb begin
      i_win = 1'b0;
      d_win = 1'b0;
      if (rst) begin
         if (i_req && (!d_req || (starve_cnt == CW'(STARVE_MAX))))
            i_win = 1'b1;
         else if (d_req)
            d_win = 1'b1;
      end
   end

   assign i_gnt = i_win;
   assign d_gnt = d_win;

   // Memory request mux; all fields forced to zero when idle
   always_comb begin
      m_req   = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_be    = '0;
      if (i_win) begin
         m_req  = 1'b1;
         m_addr = i_addr;
         m_be   = '1;
      end else if (d_win) begin
         m_req   = 1'b1;
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
         m_be    = d_be;
      end
   end

   // Response owner: who gets m_rdata next cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner       <= OWN_NONE;
         owner_store <= 1'b0;
      end else if (i_win) begin
         owner       <= OWN_INSTR;
         owner_store <= 1'b0;
      end else if (d_win) begin
         owner       <= OWN_DATA;
         owner_store <= d_we;
      end else begin
         owner       <= OWN_NONE;
         owner_store <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         starve_cnt <= '0;
      else if (i_req && !i_win) begin
         if (starve_cnt != CW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
      end else
         starve_cnt <= '0;
   end

   assign i_rvalid = (owner == OWN_INSTR);
   assign d_rvalid = (owner == OWN_DATA);
   assign i_rdata  = i_rvalid ? m_rdata : '0;
   assign d_rdata  = (d_rvalid && !owner_store) ? m_rdata : '0;

endmodule

// File: tb/tb_single_cycle_mem_arbiter.sv
// Randomized and directed checks of single_cycle_mem_arbiter against a transaction-level model
// with a shadow memory, next to a behavioural single-port memory.
module tb_single_cycle_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int SMAX = 4;

   logic          clk, rst;
   logic          i_req, i_gnt, i_rvalid;
   logic [31:0]   i_addr, i_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid;
   logic [31:0]   d_addr, d_wdata, d_rdata;
   logic [3:0]    d_be;
   logic          m_req, m_we;
   logic [31:0]   m_addr, m_wdata, m_rdata;
   logic [3:0]    m_be;

   single_cycle_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_rdata(m_rdata)
   );

   int compares = 0;
   int errors   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] hash(int k);
      return (32'(k) * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   // Memory environment: 256 words; read data garbage whenever no read was issued
   logic [31:0] mem [256];
   logic        mem_init;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 256; k++) mem[k] <= hash(k);
      end else if (m_req && m_we) begin
         for (int b = 0; b < 4; b++)
            if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
         m_rdata <= $urandom;
      end else if (m_req) begin
         m_rdata <= mem[m_addr[9:2]];
      end else begin
         m_rdata <= $urandom;
      end
   end

   // Reference model state: starvation count, pending response kind (0 none, 1 fetch, 2 load, 3 store)
   logic [31:0] shadow [256];
   int          cnt;
   int          pend;
   logic [31:0] pend_data;
   logic        e_i_gnt, e_d_gnt, e_m_req, e_m_we, e_i_rvalid, e_d_rvalid;
   logic [31:0] e_m_addr, e_m_wdata, e_i_rdata, e_d_rdata;
   logic [3:0]  e_m_be;

   function automatic logic [137:0] obs_vec();
      return {i_gnt, d_gnt, m_req, m_we, m_addr, m_wdata, m_be, i_rvalid, i_rdata, d_rvalid, d_rdata};
   endfunction

   function automatic logic [137:0] exp_vec();
      return {e_i_gnt, e_d_gnt, e_m_req, e_m_we, e_m_addr, e_m_wdata, e_m_be,
              e_i_rvalid, e_i_rdata, e_d_rvalid, e_d_rdata};
   endfunction

   task automatic model_reset();
      cnt = 0;
      pend = 0;
      pend_data = 32'h0;
   endtask

   task automatic predict();
      logic iw, dw;
      iw = i_req && (!d_req || cnt == SMAX);
      dw = d_req && !iw;
      e_i_gnt   = iw;
      e_d_gnt   = dw;
      e_m_req   = iw || dw;
      e_m_we    = dw && d_we;
      e_m_addr  = iw ? i_addr : (dw ? d_addr : 32'h0);
      e_m_wdata = dw ? d_wdata : 32'h0;
      e_m_be    = iw ? 4'hF : (dw ? d_be : 4'h0);
      e_i_rvalid = (pend == 1);
      e_i_rdata  = (pend == 1) ? pend_data : 32'h0;
      e_d_rvalid = (pend >= 2);
      e_d_rdata  = (pend == 2) ? pend_data : 32'h0;
   endtask

   task automatic advance();
      @(posedge clk);
      if (e_i_gnt) begin
         pend = 1;
         pend_data = shadow[int'(i_addr[9:2])];
      end else if (e_d_gnt && d_we) begin
         for (int b = 0; b < 4; b++)
            if (d_be[b]) shadow[int'(d_addr[9:2])][8*b +: 8] = d_wdata[8*b +: 8];
         pend = 3;
         pend_data = 32'h0;
      end else if (e_d_gnt) begin
         pend = 2;
         pend_data = shadow[int'(d_addr[9:2])];
      end else begin
         pend = 0;
      end
      cnt = (i_req && !e_i_gnt) ? ((cnt + 1 > SMAX) ? SMAX : cnt + 1) : 0;
      #1;
   endtask

   task automatic set_idle();
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_init = 1'b1;
      i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b1;
      d_addr = 32'h20; d_wdata = 32'hFFFF_FFFF; d_be = 4'hF;
      for (int k = 0; k < 256; k++) shadow[k] = hash(k);
      model_reset();
      repeat (2) @(posedge clk);
      #4;
      compares++;
      if (obs_vec() !== 138'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", obs_vec());
      end
      @(posedge clk); #1;
      mem_init = 1'b0; rst = 1'b1;
      set_idle();
   endtask

   task automatic test_fetch();
      for (int k = 0; k < 4; k++) begin
         i_req = (k < 3); i_addr = 32'(4 * k); d_req = 1'b0;
         predict(); #3;
         compares++;
         if (i_gnt !== e_i_gnt || m_addr !== e_m_addr || m_be !== e_m_be) begin
            errors++;
            $display("FAIL fetch_grant[%0d]: got gnt=%b addr=%h be=%h expected gnt=%b addr=%h be=%h",
                     k, i_gnt, m_addr, m_be, e_i_gnt, e_m_addr, e_m_be);
         end
         compares++;
         if (i_rvalid !== e_i_rvalid || i_rdata !== e_i_rdata) begin
            errors++;
            $display("FAIL fetch_resp[%0d]: got v=%b data=%h expected v=%b data=%h",
                     k, i_rvalid, i_rdata, e_i_rvalid, e_i_rdata);
         end
         advance();
      end
   endtask

   task automatic test_simultaneous();
      i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'h0;
      predict(); #3;
      compares++;
      if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || m_addr !== 32'h100 || m_we !== 1'b0) begin
         errors++;
         $display("FAIL simul_arb: got d_gnt=%b i_gnt=%b m_addr=%h m_we=%b expected 1 0 00000100 0",
                  d_gnt, i_gnt, m_addr, m_we);
      end
      advance();
      d_req = 1'b0;
      predict(); #3;
      compares++;
      if (d_rvalid !== 1'b1 || i_gnt !== 1'b1 || d_rdata !== e_d_rdata) begin
         errors++;
         $display("FAIL simul_next: got d_rvalid=%b i_gnt=%b d_rdata=%h expected 1 1 %h",
                  d_rvalid, i_gnt, d_rdata, e_d_rdata);
      end
      advance();
      set_idle();
      predict(); #3;
      compares++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL simul_tail: got %h expected %h", obs_vec(), exp_vec());
      end
      advance();
   endtask

   task automatic test_idle();
      set_idle();
      for (int k = 0; k < 5; k++) begin
         predict(); #3;
         compares++;
         if (m_req !== 1'b0 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL idle[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
         end
         advance();
      end
   endtask

   task automatic test_starvation();
      int first_i;
      first_i = -1;
      i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180; d_be = 4'h0;
      for (int k = 0; k < 10; k++) begin
         predict(); #3;
         if (i_gnt === 1'b1 && first_i < 0) first_i = k;
         compares++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL starve[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
         end
         advance();
      end
      compares++;
      if (first_i != SMAX) begin
         errors++;
         $display("FAIL starve_first_fetch: got cycle %0d expected cycle %0d", first_i, SMAX);
      end
      set_idle();
      predict(); #3; advance();
   endtask

   task automatic test_store();
      i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
      predict(); #3;
      compares++;
      if (m_we !== 1'b1 || m_wdata !== 32'hDEADBEEF || m_be !== 4'hF || m_addr !== 32'h20 || d_gnt !== 1'b1) begin
         errors++;
         $display("FAIL store_req: got we=%b wdata=%h be=%h addr=%h gnt=%b", m_we, m_wdata, m_be, m_addr, d_gnt);
      end
      advance();
      d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'h20;
      predict(); #3;
      compares++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin
         errors++;
         $display("FAIL store_ack: got v=%b data=%h expected 1 00000000", d_rvalid, d_rdata);
      end
      advance();
      set_idle();
      predict(); #3;
      compares++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL store_readback: got v=%b data=%h expected 1 deadbeef", i_rvalid, i_rdata);
      end
      advance();
   endtask

   task automatic test_reset_mid();
      i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'h0;
      predict(); #1;
      compares++;
      if (d_gnt !== 1'b1 || m_addr !== 32'h40) begin
         errors++;
         $display("FAIL rstmid_grant: got gnt=%b addr=%h expected 1 00000040", d_gnt, m_addr);
      end
      rst = 1'b0; #1;
      compares++;
      if (obs_vec() !== 138'h0) begin
         errors++;
         $display("FAIL rstmid_async: got %h expected 0", obs_vec());
      end
      repeat (2) @(posedge clk);
      #1;
      compares++;
      if (obs_vec() !== 138'h0) begin
         errors++;
         $display("FAIL rstmid_held: got %h expected 0", obs_vec());
      end
      set_idle();
      rst = 1'b1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         predict(); #3;
         compares++;
         if (d_rvalid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rstmid_after[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
         end
         advance();
      end
   endtask

   // Random traffic; requesters keep req and fields stable until granted
   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if (!(i_req && !e_i_gnt)) begin
            i_req  = ($urandom_range(0, 3) != 0);
            i_addr = 32'($urandom_range(0, 255)) << 2;
         end
         if (!(d_req && !e_d_gnt)) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = 32'($urandom_range(0, 255)) << 2;
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(0, 15));
         end
         predict(); #3;
         compares++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
         end
         advance();
      end
   endtask

   initial begin
      e_i_gnt = 1'b0; e_d_gnt = 1'b0;
      test_reset();
      test_fetch();
      test_simultaneous();
      test_idle();
      test_starvation();
      test_store();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/single_cycle_mem_arbiter.md
SINGLE_CYCLE_MEM_ARBITER -- requirements
Module: single_cycle_mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width in bits.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, meaning consecutive denied instruction-request cycles before instruction wins.
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port i_req  input  1  fetch request.
REQ-007 The block SHALL have port i_addr  input  AW  fetch address.
REQ-008 The block SHALL have port i_gnt  output  1  fetch request accepted this cycle.
REQ-009 The block SHALL have port i_rvalid  output  1  fetch data valid.
REQ-010 The block SHALL have port i_rdata  output  DW  fetch data.
REQ-011 The block SHALL have port d_req  input  1  load/store request.
REQ-012 The block SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-013 The block SHALL have port d_addr  input  AW  load/store address.
REQ-014 The block SHALL have port d_wdata  input  DW  store data.
REQ-015 The block SHALL have port d_be  input  DW/8  store byte enables.
REQ-016 The block SHALL have port d_gnt  output  1  load/store request accepted this cycle.
REQ-017 The block SHALL have port d_rvalid  output  1  load data valid or store acknowledge.
REQ-018 The block SHALL have port d_rdata  output  DW  load data.
REQ-019 The block SHALL have port m_req, m_we, m_addr, m_wdata, m_be  outputs  1/1/AW/DW/DW/8  shared single-port memory request; memory always accepts.
REQ-020 The block SHALL have port m_rdata  input  DW  memory read data, valid exactly one cycle after an accepted read.

Function
REQ-021 The block SHALL grant at most one requester per cycle; grant and m_* drive are combinational from req inputs and arbiter state.
REQ-022 The block SHALL give d_req priority over i_req unless the starvation counter equals STARVE_MAX, in which case i_req wins.
REQ-023 The starvation counter SHALL increment (saturating at STARVE_MAX) each cycle i_req=1 and i_gnt=0; it SHALL clear when i_gnt=1 or i_req=0.
REQ-024 When no request is present, m_req SHALL be 0, m_we 0, and m_addr/m_wdata/m_be SHALL be 0.
REQ-025 For a granted fetch, m_we SHALL be 0 and m_be all ones; for a granted data request, m_we=d_we, m_be=d_be, m_wdata=d_wdata.
REQ-026 A response-owner register (states NONE, INSTR, DATA) SHALL capture the winner each cycle; NONE when nothing granted.
REQ-027 In the cycle after an instruction grant, i_rvalid SHALL be 1 and i_rdata=m_rdata; latency grant-to-rvalid is exactly 1 cycle.
REQ-028 In the cycle after a data grant, d_rvalid SHALL be 1; d_rdata=m_rdata for loads, 0 for stores.
REQ-029 Back-to-back grants SHALL be supported: a new grant in the same cycle a prior response is returned, full throughput one access per cycle.
REQ-030 i_rdata/d_rdata SHALL be 0 whenever the corresponding rvalid is 0.
REQ-031 Requesters hold req and request fields stable until gnt; the block SHALL NOT latch request fields.

Reset
REQ-032 While rst=0, all outputs SHALL be 0, starvation counter 0, response owner NONE, regardless of clk.
REQ-033 Reset asserted with a response outstanding SHALL discard it; no rvalid SHALL appear after rst deasserts for pre-reset grants.
REQ-034 The first cycle after rst rises SHALL arbitrate normally from counter 0.

Verification
REQ-035 Fetch only: i_req=1, i_addr=0x0,0x4,0x8 consecutive -> i_gnt=1 each cycle, i_rvalid each following cycle, i_rdata = memory contents at 0x0,0x4,0x8.
REQ-036 Simultaneous: i_req=d_req=1, d_we=0, d_addr=0x100 -> d_gnt=1, i_gnt=0, m_addr=0x100; next cycle d_rvalid=1, i_gnt=1.
REQ-037 Starvation: d_req held 1 for 10 cycles with i_req=1, STARVE_MAX=4 -> i_gnt=1 on the 5th cycle, then counter clears and d wins again.
REQ-038 Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, d_be=0xF -> m_we=1, memory word 0x20 = 0xDEADBEEF, d_rvalid=1 next cycle with d_rdata=0.
REQ-039 Reset mid-op: grant load at 0x40, drop rst to 0 before next edge -> all outputs 0 immediately, no d_rvalid after rst returns to 1.
REQ-040 Idle: i_req=d_req=0 for 5 cycles -> m_req=0, both rvalid=0, counter stays 0.
